decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised multi-cycle decode/issue stage for the RISC-V core. Successor to the fixed-width decode block.
- Accepts one instruction per handshake and decodes OP-IMM, OP (R-type) and LUI. Reads the register file, presents operands and opcode to the ALU, then writes the result back.
- Adds a ready/busy back-pressure output, x0 write suppression, sign-extended immediates and parametrised widths.
- Sits between the fetch unit and the ALU/register-file pair.

Parameters:
- XLEN, 32, datapath width in bits; must be at least 12.
- RF_ADDR_W, 5, register address width.
- ALU_OP_W, 8, ALU opcode width; must be at least 4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- instruction_RDY_BSY  in  1  instruction valid from fetch
- instruction  in  32  instruction word
- instr_ready  out  1  stage can accept an instruction (high only in IDLE)
- alu_result  in  XLEN  combinational ALU result
- alu_opcode  out  ALU_OP_W  ALU operation
- alu_imm1  out  XLEN  ALU operand A
- alu_imm2  out  XLEN  ALU operand B
- RF_chip_enable  out  1  register-file access strobe
- RF_write_enable  out  1  1 = write, 0 = read
- RF_reg1_data  in  XLEN  rs1 read data, valid the cycle after the read strobe
- RF_reg2_data  in  XLEN  rs2 read data, valid the cycle after the read strobe
- RF_rs1_address  out  RF_ADDR_W  rs1 address
- RF_rs2_address  out  RF_ADDR_W  rs2 address
- RF_WR_add  out  RF_ADDR_W  write-back address
- RF_WriteData  out  XLEN  write-back data
- illegal_instr  out  1  only when DECODE_ILLEGAL_TRAP_EN is defined; see Optional Feature

Behaviour:
- Reset (rst=0, asynchronous):
  - state returns to IDLE
  - all outputs 0 except instr_ready=1
  - capture registers cleared
  - reset mid-operation aborts the instruction with no register-file write
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready=1
  - if instruction_RDY_BSY=1, capture the instruction and go to READ
  - otherwise stay in IDLE
- READ (1 cycle):
  - RF_chip_enable=1, RF_write_enable=0
  - RF_rs1_address=instr[19:15], RF_rs2_address=instr[24:20], each truncated or zero-extended to RF_ADDR_W
  - go to EXEC
- EXEC (1 cycle): drive ALU operands and opcode; latch alu_result at the clock edge; go to WB.
  - OP-IMM (0010011): imm1=reg1; imm2=sext(instr[31:20]) to XLEN.
  - OP (0110011): imm1=reg1; imm2=reg2.
  - LUI (0110111): imm1=0; imm2={instr[31:12],12'b0}, sign-extended to XLEN.
  - alu_opcode zero-extended to ALU_OP_W:
    - {b5,funct3}, where b5=instr[30] for OP and for OP-IMM shifts (funct3=101); otherwise b5=0
    - LUI uses ADD (0)
- WB (1 cycle):
  - RF_chip_enable=1, RF_write_enable=1
  - RF_WR_add=instr[11:7]; RF_WriteData=latched result
  - if rd=0: RF_chip_enable=0 and RF_write_enable=0 (x0 write suppressed)
  - return to IDLE
- Unsupported opcode: READ is skipped and WB performs no write. The instruction is consumed in 2 cycles (IDLE then EXEC).
- Throughput: one supported instruction per 4 cycles. instr_ready is low during READ, EXEC and WB; instruction_RDY_BSY is ignored in those states.
- Outputs are registered or decoded from the state only, with no combinational path from instruction. Exception: alu_result is sampled in EXEC.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined: illegal_instr is a registered output. It pulses 1 for one cycle, in EXEC, for an unsupported opcode or for OP with funct7 not in {0000000, 0100000}.
- Not defined: the port is absent; unsupported instructions are silently discarded.

Decomposition:
- Shared package holds:
  - opcode constants OPC_OP_IMM, OPC_OP, OPC_LUI
  - state encoding (IDLE=0, READ=1, EXEC=2, WB=3)
  - ALU opcode constants ALU_ADD=0, ALU_SUB=8
- One natural sub-module: decode_imm_gen. It is combinational and produces the sign-extended I and U immediates at XLEN.

Test Plan:
- addi x2,x1,3 (0x00308113), reg1=5, alu_result=8: READ rs1=1; EXEC imm1=5, imm2=3, opcode=0x00; WB WR_add=2, WriteData=8, write_enable=1.
- sub x3,x1,x2 (0x402081B3), reg1=9, reg2=4, alu_result=5: EXEC opcode=0x08, imm2=4; WB WR_add=3, WriteData=5.
- addi x1,x0,-1 (0xFFF00093): imm2=0xFFFFFFFF. Repeat with XLEN=64: imm2=0xFFFFFFFFFFFFFFFF.
- lui x5,0x12345 (0x123452B7): imm1=0, imm2=0x12345000, opcode=0. addi x0,x1,1: WB has RF_chip_enable=0.
- Hold instruction_RDY_BSY=1 for 8 cycles: instr_ready pattern 1,0,0,0,1,0,0,0; exactly two instructions accepted.
- Drop rst to 0 during EXEC: all outputs 0 immediately with instr_ready=1, and no WB write. Opcode 0x0000007F: no register-file write; illegal_instr=1 for one cycle when the macro is defined.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcode, state and ALU opcode constants shared by the decode stage.
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StExec = 2'd2,
    StWb   = 2'd3
  } state_e;

  function automatic logic is_supported(input logic [6:0] opc);
    return (opc == OPC_OP_IMM) || (opc == OPC_OP) || (opc == OPC_LUI);
  endfunction

  // {b5, funct3}; b5 only distinguishes SUB/SRA (OP) and SRAI (OP-IMM shift-right).
  function automatic logic [3:0] alu_op_of(input logic [6:0] opc, input logic [2:0] funct3,
                                           input logic bit30);
    logic b5;
    b5 = 1'b0;
    if (opc == OPC_OP) begin
      b5 = bit30;
    end else if (opc == OPC_OP_IMM && funct3 == 3'b101) begin
      b5 = bit30;
    end
    if (opc != OPC_OP && opc != OPC_OP_IMM) begin
      return ALU_ADD;
    end
    return {b5, funct3};
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// decode_imm_gen: sign-extended I-type and U-type immediates at XLEN (combinational).
module decode_imm_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [19:0]     upper_i,  // instruction bits [31:12]
  output logic [XLEN-1:0] imm_i_o,
  output logic [XLEN-1:0] imm_u_o
);

  logic signed [11:0] imm_i_raw;
  logic signed [31:0] imm_u_raw;

  assign imm_i_raw = upper_i[19:8];
  assign imm_u_raw = {upper_i, 12'b0};

  // Size casts of signed values sign-extend (or truncate when XLEN < 32).
  assign imm_i_o = XLEN'(imm_i_raw);
  assign imm_u_o = XLEN'(imm_u_raw);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: multi-cycle decode/issue stage, IDLE -> READ -> EXEC -> WB.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds the registered illegal_instr output.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned ALU_OP_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instruction_RDY_BSY,
  input  logic [31:0]          instruction,
  output logic                 instr_ready,
  input  logic [XLEN-1:0]      alu_result,
  output logic [ALU_OP_W-1:0]  alu_opcode,
  output logic [XLEN-1:0]      alu_imm1,
  output logic [XLEN-1:0]      alu_imm2,
  output logic                 RF_chip_enable,
  output logic                 RF_write_enable,
  input  logic [XLEN-1:0]      RF_reg1_data,
  input  logic [XLEN-1:0]      RF_reg2_data,
  output logic [RF_ADDR_W-1:0] RF_rs1_address,
  output logic [RF_ADDR_W-1:0] RF_rs2_address,
  output logic [RF_ADDR_W-1:0] RF_WR_add,
  output logic [XLEN-1:0]      RF_WriteData
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_instr
`endif
);

  state_e               state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic [XLEN-1:0]      result_q, result_d;

  logic                 ready_q, ready_d;
  logic                 ce_q, ce_d;
  logic                 we_q, we_d;
  logic [RF_ADDR_W-1:0] rs1_q, rs1_d;
  logic [RF_ADDR_W-1:0] rs2_q, rs2_d;
  logic [RF_ADDR_W-1:0] wr_add_q, wr_add_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [ALU_OP_W-1:0]  alu_op_q, alu_op_d;

  logic [XLEN-1:0]      imm_i, imm_u;

  decode_imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .upper_i(instr_q[31:12]),
    .imm_i_o(imm_i),
    .imm_u_o(imm_u)
  );

  // Next state, instruction capture and ALU result latch.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (instruction_RDY_BSY) begin
          instr_d = instruction;
          // Unsupported opcodes skip the register read and are dropped after EXEC.
          state_d = is_supported(instruction[6:0]) ? StRead : StExec;
        end
      end
      StRead: state_d = StExec;
      StExec: begin
        result_d = alu_result;
        state_d  = is_supported(instr_q[6:0]) ? StWb : StIdle;
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output registers are loaded from the state being entered, so they line up with it.
  always_comb begin
    ready_d  = (state_d == StIdle);
    ce_d     = 1'b0;
    we_d     = 1'b0;
    rs1_d    = '0;
    rs2_d    = '0;
    wr_add_d = '0;
    wdata_d  = '0;
    alu_op_d = '0;
    case (state_d)
      StRead: begin
        ce_d  = 1'b1;
        rs1_d = RF_ADDR_W'(instr_d[19:15]);
        rs2_d = RF_ADDR_W'(instr_d[24:20]);
      end
      StExec: begin
        alu_op_d = ALU_OP_W'(alu_op_of(instr_d[6:0], instr_d[14:12], instr_d[30]));
      end
      StWb: begin
        // x0 is hard-wired to zero: suppress the strobe entirely.
        ce_d     = (instr_d[11:7] != 5'd0);
        we_d     = (instr_d[11:7] != 5'd0);
        wr_add_d = RF_ADDR_W'(instr_d[11:7]);
        wdata_d  = result_d;
      end
      default: ;
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      instr_q  <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      wr_add_q <= '0;
      wdata_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      wr_add_q <= wr_add_d;
      wdata_q  <= wdata_d;
      alu_op_q <= alu_op_d;
    end
  end

  // ALU operands: register-file data is only valid in EXEC, so these are muxed live.
  always_comb begin
    alu_imm1 = '0;
    alu_imm2 = '0;
    if (state_q == StExec) begin
      case (instr_q[6:0])
        OPC_OP_IMM: begin
          alu_imm1 = RF_reg1_data;
          alu_imm2 = imm_i;
        end
        OPC_OP: begin
          alu_imm1 = RF_reg1_data;
          alu_imm2 = RF_reg2_data;
        end
        OPC_LUI: begin
          alu_imm2 = imm_u;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready     = ready_q;
  assign RF_chip_enable  = ce_q;
  assign RF_write_enable = we_q;
  assign RF_rs1_address  = rs1_q;
  assign RF_rs2_address  = rs2_q;
  assign RF_WR_add       = wr_add_q;
  assign RF_WriteData    = wdata_q;
  assign alu_opcode      = alu_op_q;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Flag is raised on entry to EXEC and lasts exactly that cycle.
  always_comb begin
    illegal_d = 1'b0;
    if (state_d == StExec) begin
      illegal_d = !is_supported(instr_d[6:0]) ||
                  ((instr_d[6:0] == OPC_OP) && (instr_d[31:25] != 7'b0000000) &&
                   (instr_d[31:25] != 7'b0100000));
    end
  end

  // Illegal-instruction flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_instr = illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a transaction model.
module tb_decode_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned OW   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy_bsy;
  logic [31:0]     instr;
  logic            instr_ready;
  logic [XLEN-1:0] alu_result, alu_imm1, alu_imm2, reg1, reg2, wdata;
  logic [OW-1:0]   alu_opcode;
  logic            ce, we;
  logic [AW-1:0]   rs1a, rs2a, wadd;

  // Second instance at XLEN=64 shares the instruction stream; only its imm2 is checked.
  logic            ready_64, ce_64, we_64;
  logic [63:0]     res_64, imm1_64, imm2_64, reg1_64, reg2_64, wdata_64;
  logic [OW-1:0]   op_64;
  logic [AW-1:0]   rs1_64, rs2_64, wadd_64;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal, illegal_64;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign res_64  = 64'(alu_result);
  assign reg1_64 = 64'(reg1);
  assign reg2_64 = 64'(reg2);

  decode_stage #(.XLEN(XLEN), .RF_ADDR_W(AW), .ALU_OP_W(OW)) u_dut (
    .clk                (clk),
    .rst                (rst),
    .instruction_RDY_BSY(rdy_bsy),
    .instruction        (instr),
    .instr_ready        (instr_ready),
    .alu_result         (alu_result),
    .alu_opcode         (alu_opcode),
    .alu_imm1           (alu_imm1),
    .alu_imm2           (alu_imm2),
    .RF_chip_enable     (ce),
    .RF_write_enable    (we),
    .RF_reg1_data       (reg1),
    .RF_reg2_data       (reg2),
    .RF_rs1_address     (rs1a),
    .RF_rs2_address     (rs2a),
    .RF_WR_add          (wadd),
    .RF_WriteData       (wdata)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .illegal_instr      (illegal)
`endif
  );

  decode_stage #(.XLEN(64), .RF_ADDR_W(AW), .ALU_OP_W(OW)) u_dut64 (
    .clk                (clk),
    .rst                (rst),
    .instruction_RDY_BSY(rdy_bsy),
    .instruction        (instr),
    .instr_ready        (ready_64),
    .alu_result         (res_64),
    .alu_opcode         (op_64),
    .alu_imm1           (imm1_64),
    .alu_imm2           (imm2_64),
    .RF_chip_enable     (ce_64),
    .RF_write_enable    (we_64),
    .RF_reg1_data       (reg1_64),
    .RF_reg2_data       (reg2_64),
    .RF_rs1_address     (rs1_64),
    .RF_rs2_address     (rs2_64),
    .RF_WR_add          (wadd_64),
    .RF_WriteData       (wdata_64)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .illegal_instr      (illegal_64)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // What one instruction should do, derived from the ISA rules.
  typedef struct packed {
    logic        sup;
    logic        wr;
    logic        ill;
    logic        imm1_zero;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [63:0] imm2;     // immediate operand at 64 bits (unused for OP)
    logic        use_imm;
  } exp_t;

  function automatic exp_t model(input logic [31:0] w);
    exp_t   e;
    longint v;
    int     opc, f3, f7;
    opc = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    e   = '0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.sup = (opc == 'h13) || (opc == 'h33) || (opc == 'h37);
    e.wr  = e.sup && (e.rd != 5'd0);
    e.ill = !e.sup || ((opc == 'h33) && (f7 != 0) && (f7 != 32));
    if (opc == 'h13) begin
      v = longint'(w[31:20]);
      if (v >= 2048) v -= 4096;
      e.imm2    = v;
      e.use_imm = 1'b1;
      e.op      = 4'(f3 + (((f3 == 5) && w[30]) ? 8 : 0));
    end else if (opc == 'h33) begin
      e.op = 4'(f3 + (w[30] ? 8 : 0));
    end else if (opc == 'h37) begin
      v = longint'(w[31:12]) * 4096;
      if (v >= (longint'(1) << 31)) v -= (longint'(1) << 32);
      e.imm2      = v;
      e.use_imm   = 1'b1;
      e.imm1_zero = 1'b1;
      e.op        = 4'd0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 5))
      0, 1: w[6:0] = 7'h13;
      2, 3: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0:       w[31:25] = 7'h00;
          1:       w[31:25] = 7'h20;
          default: ;
        endcase
      end
      4:       w[6:0] = 7'h37;
      default: ;
    endcase
    return w;
  endfunction

  // Drive one instruction from IDLE and check every phase it passes through.
  task automatic run_instr(input logic [31:0] w, input logic [XLEN-1:0] r1,
                           input logic [XLEN-1:0] r2, input logic [XLEN-1:0] res);
    exp_t            e;
    logic [63:0]     imm2_full;
    logic [XLEN-1:0] exp_imm1, exp_imm2;
    int              n;
    e = model(w);
    imm2_full = e.imm2;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_ready", 64'(instr_ready), 64'd1);
    rdy_bsy = 1'b1;
    instr   = w;
    @(negedge clk);
    // Anything presented now must be ignored.
    rdy_bsy = 1'($urandom_range(0, 1));
    instr   = $urandom();
    if (e.sup) begin
      check_eq("read_ready", 64'(instr_ready), 64'd0);
      check_eq("read_ce", 64'(ce), 64'd1);
      check_eq("read_we", 64'(we), 64'd0);
      check_eq("read_rs1", 64'(rs1a), 64'(e.rs1));
      check_eq("read_rs2", 64'(rs2a), 64'(e.rs2));
      reg1 = r1;
      reg2 = r2;
      @(negedge clk);
    end
    check_eq("exec_ready", 64'(instr_ready), 64'd0);
    check_eq("exec_ce", 64'(ce), 64'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check_eq("exec_illegal", 64'(illegal), 64'(e.ill));
`endif
    if (e.sup) begin
      exp_imm1 = e.imm1_zero ? '0 : r1;
      exp_imm2 = e.use_imm ? imm2_full[XLEN-1:0] : r2;
      check_eq("exec_opcode", 64'(alu_opcode), 64'(e.op));
      check_eq("exec_imm1", 64'(alu_imm1), 64'(exp_imm1));
      check_eq("exec_imm2", 64'(alu_imm2), 64'(exp_imm2));
      if (e.use_imm) check_eq("exec_imm2_x64", imm2_64, e.imm2);
    end
    alu_result = res;
    @(negedge clk);
    rdy_bsy = 1'b0;
    if (e.sup) begin
      check_eq("wb_ready", 64'(instr_ready), 64'd0);
      check_eq("wb_ce", 64'(ce), 64'(e.wr));
      check_eq("wb_we", 64'(we), 64'(e.wr));
`ifdef DECODE_ILLEGAL_TRAP_EN
      check_eq("wb_illegal", 64'(illegal), 64'd0);
`endif
      if (e.wr) begin
        check_eq("wb_addr", 64'(wadd), 64'(e.rd));
        check_eq("wb_data", 64'(wdata), 64'(res));
      end
    end else begin
      // Back in IDLE already: nothing may have been written.
      check_eq("drop_ready", 64'(instr_ready), 64'd1);
      check_eq("drop_ce", 64'(ce), 64'd0);
    end
  endtask

  task automatic check_all_idle(input string tag);
    check_eq({tag, "_ready"}, 64'(instr_ready), 64'd1);
    check_eq({tag, "_ce_we"}, 64'({ce, we}), 64'd0);
    check_eq({tag, "_addrs"}, 64'({rs1a, rs2a, wadd}), 64'd0);
    check_eq({tag, "_wdata"}, 64'(wdata), 64'd0);
    check_eq({tag, "_opcode"}, 64'(alu_opcode), 64'd0);
    check_eq({tag, "_imm1"}, 64'(alu_imm1), 64'd0);
    check_eq({tag, "_imm2"}, 64'(alu_imm2), 64'd0);
  endtask

  initial begin
    logic [7:0] pat;
    int         accepted;
    int         writes;

    rst        = 1'b0;
    rdy_bsy    = 1'b0;
    instr      = '0;
    alu_result = '0;
    reg1       = '0;
    reg2       = '0;
    #12;
    check_all_idle("reset");
    @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    run_instr(32'h00308113, 32'd5, 32'd0, 32'd8);             // addi x2,x1,3
    run_instr(32'h402081B3, 32'd9, 32'd4, 32'd5);             // sub x3,x1,x2
    run_instr(32'hFFF00093, 32'd0, 32'd0, 32'hFFFF_FFFF);     // addi x1,x0,-1
    run_instr(32'h123452B7, 32'd77, 32'd66, 32'h1234_5000);   // lui x5,0x12345
    run_instr(32'h00108013, 32'd3, 32'd0, 32'd4);             // addi x0,x1,1
    run_instr(32'h0000007F, 32'd1, 32'd2, 32'd3);             // unsupported opcode
    run_instr(32'h4050D093, 32'd8, 32'd0, 32'd1);             // srai x1,x1,5
    run_instr(32'h7E0081B3, 32'd1, 32'd2, 32'd3);             // OP with bad funct7

    // Randomized instructions.
    for (int i = 0; i < 60; i++) begin
      run_instr(rand_instr(), $urandom(), $urandom(), $urandom());
    end

    // Back-to-back requests: one accept every four cycles.
    pat      = '0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat = {pat[6:0], instr_ready};
      if (instr_ready) accepted++;
      rdy_bsy = 1'b1;
      instr   = 32'h00308113;
    end
    @(negedge clk);
    rdy_bsy = 1'b0;
    check_eq("bp_pattern", 64'(pat), 64'h88);
    check_eq("bp_accepted", 64'(accepted), 64'd2);

    // Reset while in EXEC aborts the instruction.
    @(negedge clk);
    check_eq("abort_idle", 64'(instr_ready), 64'd1);
    rdy_bsy = 1'b1;
    instr   = 32'h00308113;
    @(negedge clk);
    rdy_bsy = 1'b0;
    reg1    = 32'd5;
    @(negedge clk);
    check_eq("abort_pre_imm1", 64'(alu_imm1), 64'd5);
    alu_result = 32'd8;
    #2;
    rst = 1'b0;
    #1;
    check_all_idle("abort");
    @(negedge clk);
    rst    = 1'b1;
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ce || we) writes++;
    end
    check_eq("abort_no_wb", 64'(writes), 64'd0);

    // Pipeline still works after the abort.
    run_instr(32'h402081B3, 32'd20, 32'd7, 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
